fnorm32: RTL

FNORM32 -- requirements
Module: fnorm32

---
 rtl/fnorm32.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fnorm32.sv
// fnorm32 -- normalise, round and pack the raw sum of a single-precision adder.
//
// Takes the raw mantissa sum of an IEEE-754 single-precision add (with its
// carry-out, sign and larger-operand exponent). It normalises the mantissa,
// rounds to nearest-even and packs the result into a 32-bit word. It handles
// one operation at a time.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   raw sum available
//   in_ready   block idle, accepts a raw sum
//   in_sign    result sign
//   in_exp     biased exponent of the larger operand
//   in_cout    mantissa-add carry-out (bit 27 of the raw value)
//   in_man     raw mantissa: [26] hidden, [25:3] fraction, [2] guard, [1:0] round/sticky
//   out_valid  packed result available
//   out_ready  consumer takes the result
//   out_res    packed IEEE-754 single
//   out_ovf    result overflowed to infinity
module fnorm32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic        in_cout,
  input  logic [26:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [27:0] man_r, man_s;
  logic [9:0]  exp_r, exp_s;
  logic        sign_r, sign_s;
  logic [31:0] res_r, res_s;
  logic        ovf_r, ovf_s;

  // Rounding datapath, used only while in ROUND.
  logic        round_inc_s;
  logic [27:0] man_rnd_s;
  logic [27:0] man_fin_s;
  logic [9:0]  exp_fin_s;

  // Round-to-nearest-even at bit 3, then renormalise if the increment carried into bit 27.
  always_comb begin
    round_inc_s = man_r[2] & (man_r[1] | man_r[0] | man_r[3]);
    man_rnd_s   = man_r + {24'd0, round_inc_s, 3'b000};
    if (man_rnd_s[27]) begin
      man_fin_s = {1'b0, man_rnd_s[27:1]};
      exp_fin_s = exp_r + 10'd1;
    end else begin
      man_fin_s = man_rnd_s;
      exp_fin_s = exp_r;
    end
  end

  // Next-state and datapath updates for the normalise/round/pack sequence.
  always_comb begin
    state_s = state_r;
    man_s   = man_r;
    exp_s   = exp_r;
    sign_s  = sign_r;
    res_s   = res_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          man_s   = {in_cout, in_man};
          // Exponent 0 (subnormal operands) behaves as exponent 1.
          exp_s   = (in_exp == 8'd0) ? 10'd1 : {2'b00, in_exp};
          sign_s  = in_sign;
          state_s = NORM;
        end else begin
          state_s = IDLE;
        end
      end
      NORM: begin
        if (man_r == 28'd0) begin
          state_s = ROUND;
        end else if (man_r[27]) begin
          // Carry-out: shift right once, keep the lost bit as sticky.
          man_s   = {1'b0, man_r[27:2], man_r[1] | man_r[0]};
          exp_s   = exp_r + 10'd1;
          state_s = ROUND;
        end else if (!man_r[26] && (exp_r > 10'd1)) begin
          // One left shift per cycle. Stop at exponent 1 to leave a subnormal.
          man_s   = {man_r[26:0], 1'b0};
          exp_s   = exp_r - 10'd1;
          state_s = NORM;
        end else begin
          state_s = ROUND;
        end
      end
      ROUND: begin
        man_s = man_fin_s;
        exp_s = exp_fin_s;
        if (exp_fin_s >= 10'd255) begin
          res_s = {sign_r, 8'hFF, 23'h000000};
          ovf_s = 1'b1;
        end else begin
          // No hidden bit means a subnormal or zero: exponent field is 0.
          res_s = {sign_r, (man_fin_s[26] ? exp_fin_s[7:0] : 8'h00), man_fin_s[25:3]};
          ovf_s = 1'b0;
        end
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      man_r   <= 28'd0;
      exp_r   <= 10'd0;
      sign_r  <= 1'b0;
      res_r   <= 32'd0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      man_r   <= man_s;
      exp_r   <= exp_s;
      sign_r  <= sign_s;
      res_r   <= res_s;
      ovf_r   <= ovf_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_res   = res_r;
  assign out_ovf   = ovf_r;

endmodule
